// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: program counter owner and registered fetch stage feeding decode through a valid/ready handshake
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 24,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instruction_addr,
  input  logic [31:0] instruction_read,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);
  state_t state, state_n;
  logic [31:0] pc, pc_n, instr_q, instr_n, ipc_q, ipc_n, fpc_n, cnt_n;
  logic valid_n, free, hs, rd_bad;
  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= LIMIT);
  endfunction
  assign free             = !if_valid || if_ready;
  assign hs               = if_valid && if_ready;
  assign rd_bad           = bad(redirect_pc);
  assign instruction_addr = pc;
  assign if_instr         = if_valid ? instr_q : NOP_WORD;
  assign if_pc            = if_valid ? ipc_q : 32'd0;
  assign halted           = state == HALT;
  assign fault            = state == FAULT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      instr_q     <= NOP_WORD;
      ipc_q       <= 32'd0;
      fault_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_valid    <= valid_n;
      instr_q     <= instr_n;
      ipc_q       <= ipc_n;
      fault_pc    <= fpc_n;
      fetch_count <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = if_valid;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    fpc_n   = fault_pc;
    cnt_n   = fetch_count + {31'd0, hs && !(redirect_valid && !rd_bad)};
    case (state)
      IDLE: state_n = RUN;
      RUN:
        if (redirect_valid) begin
          valid_n = 1'b0;
          if (rd_bad) begin
            state_n = FAULT;
            fpc_n   = redirect_pc;
          end else begin
            pc_n    = redirect_pc;
            state_n = halt_req ? HALT : RUN;
          end
        end else if (halt_req) begin
          if (free) begin
            valid_n = 1'b0;
            state_n = HALT;
          end
        end else if (free && bad(pc)) begin
          state_n = FAULT;
          fpc_n   = pc;
          valid_n = 1'b0;
        end else if (free) begin
          instr_n = instruction_read;
          ipc_n   = pc;
          valid_n = 1'b1;
          pc_n    = pc + 32'd4;
        end
      HALT:
        if (redirect_valid && rd_bad) begin
          state_n = FAULT;
          fpc_n   = redirect_pc;
        end else begin
          if (redirect_valid) pc_n = redirect_pc;
          if (!halt_req) state_n = RUN;
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench comparing the fetch stage against a queue-based behavioural model
module tb_imem_fetch_ctrl;
  localparam int          W   = 24;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FLT = 3;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} item_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] instruction_addr, instruction_read, if_instr, if_pc, fault_pc, fetch_count;
  logic if_valid, halted, fault;
  logic if_ready = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  item_t slot[$], exp_q[$];
  int n_tests = 0, n_fail = 0;
  int mode = M_IDLE;
  logic [31:0] m_pc = 32'd0, m_fpc = 32'd0, m_cnt = 32'd0;
  always #5 clk = ~clk;
  assign instruction_read = 32'hA000_0000 + (instruction_addr >> 2);
  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .instruction_addr(instruction_addr), .instruction_read(instruction_read),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(halted), .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
  );
  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(W * 4));
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("instruction_addr", instruction_addr, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, slot.size() != 0});
    chk("if_instr", if_instr, slot.size() != 0 ? slot[0].instr : NOP);
    chk("if_pc", if_pc, slot.size() != 0 ? slot[0].pc : 32'd0);
    chk("halted", {31'd0, halted}, {31'd0, mode == M_HALT});
    chk("fault", {31'd0, fault}, {31'd0, mode == M_FLT});
    chk("fault_pc", fault_pc, m_fpc);
    chk("fetch_count", fetch_count, m_cnt);
  endtask
  task automatic model(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc, input bit hq);
    bit acc;
    acc = slot.size() != 0 && rdy;
    if (r) begin
      mode = M_IDLE; m_pc = 32'd0; m_fpc = 32'd0; m_cnt = 32'd0;
      slot.delete();
      return;
    end
    case (mode)
      M_IDLE: mode = M_RUN;
      M_RUN:
        if (rv && bad(rpc)) begin
          mode = M_FLT; m_fpc = rpc;
          if (acc) m_cnt++;
          slot.delete();
        end else if (rv) begin
          m_pc = rpc;
          slot.delete();
          if (hq) mode = M_HALT;
        end else begin
          if (acc) begin
            m_cnt++;
            void'(slot.pop_front());
          end
          if (slot.size() == 0) begin
            if (hq) mode = M_HALT;
            else if (bad(m_pc)) begin
              mode = M_FLT; m_fpc = m_pc;
            end else begin
              slot.push_back('{32'hA000_0000 + (m_pc >> 2), m_pc});
              m_pc += 32'd4;
            end
          end
        end
      M_HALT:
        if (rv && bad(rpc)) begin
          mode = M_FLT; m_fpc = rpc;
        end else begin
          if (rv) m_pc = rpc;
          if (!hq) mode = M_RUN;
        end
      default: ;
    endcase
  endtask
  task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc, input bit hq);
    @(negedge clk);
    check_all();
    rst = r; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = hq;
    if (slot.size() != 0 && rdy) exp_q.push_back(slot[0]);
    model(r, rdy, rv, rpc, hq);
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (if_valid === 1'b1 && if_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL handshake: got pc %h with no expected item", if_pc);
      end else begin
        item_t e;
        e = exp_q.pop_front();
        chk("hs_instr", if_instr, e.instr);
        chk("hs_pc", if_pc, e.pc);
      end
    end
  end
  initial begin
    logic [31:0] rpc;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20 && !(slot.size() != 0 && slot[0].pc == 32'h10); i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 32'h20, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 32'h22, 0);
    for (int i = 0; i < 4; i++) step(0, $urandom_range(1), 1, 32'h8, $urandom_range(1));
    chk("fault_after_bad_redirect", {31'd0, fault}, 32'd1);
    chk("fault_pc_bad_redirect", fault_pc, 32'h22);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 40 && mode != M_FLT; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("fault_pc_range_end", fault_pc, 32'h60);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("halted_after_drain", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'h40, 1);
    step(0, 1, 1, 32'h41, 1);
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(7) == 0) ? $urandom() : {24'd0, 6'($urandom_range(W - 1)), 2'b00};
      step($urandom_range(60) == 0, $urandom_range(3) != 0, $urandom_range(9) == 0, rpc,
           $urandom_range(7) == 0);
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
